env_shared_ram: RTL and testbench

Parametrised true-dual-port shared memory between the host interface (port 1) and the environment engine (port 2). It holds the per-environment region map: state, action, start flag, observation, reward and done words. It generalises the fixed Pendulum RAM in environment count, word widths and depth. It adds byte-enable writes, a sequential clear engine, write-collision arbitration, address-range checking and a start/step-done doorbell.

---
 rtl/env_mem_pkg.sv | 49 ++++
 rtl/env_ram_clear.sv | 48 ++++
 rtl/env_shared_ram.sv | 133 +++++++++++++
 tb/tb_env_shared_ram.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/env_mem_pkg.sv
// Region-map helpers, clear-FSM state type and doorbell bit index shared by
// the env shared-RAM blocks.
package env_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  // Bit of the START word that carries the start / step-done flag.
  localparam int START_BIT = 0;

  // State words sit at address 0; actions follow them.
  function automatic int act_base(input int env_num, input int sta_wd_num);
    return env_num * sta_wd_num;
  endfunction

  function automatic int start_addr(input int env_num, input int sta_wd_num,
                                    input int act_wl, input int data_width);
    return act_base(env_num, sta_wd_num) + env_num * act_wl / data_width;
  endfunction

  function automatic int obs_base(input int env_num, input int sta_wd_num,
                                  input int act_wl, input int data_width);
    return start_addr(env_num, sta_wd_num, act_wl, data_width) + 1;
  endfunction

  function automatic int rwd_base(input int env_num, input int sta_wd_num,
                                  input int obs_wd_num, input int act_wl,
                                  input int data_width);
    return obs_base(env_num, sta_wd_num, act_wl, data_width) + env_num * obs_wd_num;
  endfunction

  function automatic int done_base(input int env_num, input int sta_wd_num,
                                   input int obs_wd_num, input int act_wl,
                                   input int rwd_wl, input int data_width);
    return rwd_base(env_num, sta_wd_num, obs_wd_num, act_wl, data_width) +
           env_num * rwd_wl / data_width;
  endfunction

  // One done bit per environment, packed into whole words.
  function automatic int map_end(input int env_num, input int sta_wd_num,
                                 input int obs_wd_num, input int act_wl,
                                 input int rwd_wl, input int data_width);
    return done_base(env_num, sta_wd_num, obs_wd_num, act_wl, rwd_wl, data_width) +
           (env_num + data_width - 1) / data_width;
  endfunction

endpackage

// File: rtl/env_ram_clear.sv
// Sequential clear engine: zeroes one word per cycle from 0 to DEPTH-1 after
// reset or an i_clear pulse, then reports ready.
module env_ram_clear
  import env_mem_pkg::*;
#(
  parameter int DEPTH      = 1360,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic                  o_clr_we,
  output logic                  o_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST = (ADDR_WIDTH)'(DEPTH - 1);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  // Clear FSM: walk the counter through every word, restart on i_clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (i_clear) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == LAST) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        ready_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_clr_addr = cnt_q;
  assign o_clr_we   = (state_q == CLEAR);
  assign o_ready    = ready_q;

endmodule

// File: rtl/env_shared_ram.sv
// True-dual-port shared RAM between host (port 1) and env engine (port 2):
// byte-enable writes, port-1-wins collision merge, range checking,
// clear engine and start/step-done doorbells on the START word.
module env_shared_ram
  import env_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 1360,
  parameter int ENV_NUM    = 192,
  parameter int STA_WD_NUM = 2,
  parameter int OBS_WD_NUM = 3,
  parameter int ACT_WL     = 32,
  parameter int RWD_WL     = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_wr1,
  input  logic                    i_wr2,
  input  logic [ADDR_WIDTH-1:0]   i_addr1,
  input  logic [ADDR_WIDTH-1:0]   i_addr2,
  input  logic [DATA_WIDTH-1:0]   i_data1,
  input  logic [DATA_WIDTH-1:0]   i_data2,
  input  logic [DATA_WIDTH/8-1:0] i_be1,
  input  logic [DATA_WIDTH/8-1:0] i_be2,
  output logic [DATA_WIDTH-1:0]   o_data1,
  output logic [DATA_WIDTH-1:0]   o_data2,
  output logic                    o_ready,
  output logic                    o_start,
  output logic                    o_step_done,
  output logic                    o_collision,
  output logic                    o_addr_err
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int START_I = start_addr(ENV_NUM, STA_WD_NUM, ACT_WL, DATA_WIDTH);
  localparam int MAP_END = map_end(ENV_NUM, STA_WD_NUM, OBS_WD_NUM, ACT_WL, RWD_WL, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] START_ADDR = (ADDR_WIDTH)'(START_I);
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH+1)'(DEPTH);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("env_shared_ram: DATA_WIDTH must be a multiple of 8");
  end
  if (MAP_END > DEPTH) begin : g_bad_map
    $error("env_shared_ram: region map does not fit in DEPTH");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("env_shared_ram: DEPTH exceeds address space");
  end

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  ready, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  env_ram_clear #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (i_clear),
    .o_clr_addr (clr_addr),
    .o_clr_we   (clr_we),
    .o_ready    (ready)
  );

  logic                  inr1, inr2, wen1, wen2, coll;
  logic [ADDR_WIDTH-1:0] ia1, ia2;
  logic [DATA_WIDTH-1:0] data1_d, data2_d, data1_q, data2_q;
  logic start_d, step_d, coll_d, err_d;
  logic start_q, step_q, coll_q, err_q;

  // Port qualification: range check, idle-only writes, same-address collision.
  always_comb begin
    inr1    = ({1'b0, i_addr1} < DEPTH_W);
    inr2    = ({1'b0, i_addr2} < DEPTH_W);
    ia1     = inr1 ? i_addr1 : '0;
    ia2     = inr2 ? i_addr2 : '0;
    wen1    = ready & ~i_wr1 & inr1;
    wen2    = ready & ~i_wr2 & inr2;
    coll    = wen1 & wen2 & (i_addr1 == i_addr2);
    data1_d = (ready & inr1) ? mem[ia1] : '0;
    data2_d = (ready & inr2) ? mem[ia2] : '0;
    start_d = wen1 & (i_addr1 == START_ADDR) & i_be1[START_BIT] & i_data1[START_BIT];
    // On a START collision only the host doorbell is considered.
    step_d  = wen2 & (i_addr2 == START_ADDR) & i_be2[START_BIT] & ~i_data2[START_BIT] & ~coll;
    coll_d  = coll;
    err_d   = ready & (~inr1 | ~inr2);
  end

  // Memory write: clear engine owns the array in CLEAR; otherwise byte-merge
  // both ports, port 1 taking any byte it also enables.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wen2 && i_be2[k] && !(coll && i_be1[k]))
          mem[ia2][8*k +: 8] <= i_data2[8*k +: 8];
        if (wen1 && i_be1[k])
          mem[ia1][8*k +: 8] <= i_data1[8*k +: 8];
      end
    end
  end

  // Registered read data (read-first) and single-cycle status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data1_q <= '0;
      data2_q <= '0;
      start_q <= 1'b0;
      step_q  <= 1'b0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      start_q <= start_d;
      step_q  <= step_d;
      coll_q  <= coll_d;
      err_q   <= err_d;
    end
  end

  assign o_data1     = data1_q;
  assign o_data2     = data2_q;
  assign o_ready     = ready;
  assign o_start     = start_q;
  assign o_step_done = step_q;
  assign o_collision = coll_q;
  assign o_addr_err  = err_q;

endmodule

// File: tb/tb_env_shared_ram.sv
// Directed bench for env_shared_ram with an expected-result scoreboard.
module tb_env_shared_ram;

  localparam int DW    = 48;
  localparam int AW    = 11;
  localparam int DEPTH = 1360;
  localparam int NB    = DW / 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_clear, i_wr1, i_wr2;
  logic [AW-1:0] i_addr1, i_addr2;
  logic [DW-1:0] i_data1, i_data2;
  logic [NB-1:0] i_be1, i_be2;
  logic [DW-1:0] o_data1, o_data2;
  logic          o_ready, o_start, o_step_done, o_collision, o_addr_err;

  env_shared_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ENV_NUM(192),
    .STA_WD_NUM(2), .OBS_WD_NUM(3), .ACT_WL(32), .RWD_WL(32)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear),
    .i_wr1(i_wr1), .i_wr2(i_wr2),
    .i_addr1(i_addr1), .i_addr2(i_addr2),
    .i_data1(i_data1), .i_data2(i_data2),
    .i_be1(i_be1), .i_be2(i_be2),
    .o_data1(o_data1), .o_data2(o_data2),
    .o_ready(o_ready), .o_start(o_start), .o_step_done(o_step_done),
    .o_collision(o_collision), .o_addr_err(o_addr_err)
  );

  always #5 i_clk = ~i_clk;

  // Pulse vector order: {start, step_done, collision, addr_err}.
  logic [3:0] pul;
  assign pul = {o_start, o_step_done, o_collision, o_addr_err};

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    bit         c1;
    logic [47:0] d1;
    bit         c2;
    logic [47:0] d2;
    logic [3:0] pul;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit c1, input logic [47:0] d1,
                      input bit c2, input logic [47:0] d2, input logic [3:0] p);
    exp_t e;
    e.tag = tag; e.c1 = c1; e.d1 = d1; e.c2 = c2; e.d2 = d2; e.pul = p;
    sbq.push_back(e);
  endtask

  // Advance one clock; compare any expectation queued for this edge.
  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.c1) chk({e.tag, "_d1"}, o_data1, e.d1);
      if (e.c2) chk({e.tag, "_d2"}, o_data2, e.d2);
      chk({e.tag, "_pulse"}, {44'd0, pul}, {44'd0, e.pul});
    end
  endtask

  task automatic p1w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    i_wr1 = 1'b0; i_addr1 = a; i_data1 = d; i_be1 = be;
  endtask
  task automatic p2w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    i_wr2 = 1'b0; i_addr2 = a; i_data2 = d; i_be2 = be;
  endtask
  task automatic p1r(input logic [AW-1:0] a);
    i_wr1 = 1'b1; i_addr1 = a; i_data1 = '0; i_be1 = '0;
  endtask
  task automatic p2r(input logic [AW-1:0] a);
    i_wr2 = 1'b1; i_addr2 = a; i_data2 = '0; i_be2 = '0;
  endtask

  initial begin
    i_rst = 1'b1; i_clear = 1'b0;
    p1r(11'd0); p2r(11'd0);

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 48'(o_ready), 48'd0);
    chk("rst_d1", o_data1, 48'd0);
    chk("rst_d2", o_data2, 48'd0);
    chk("rst_pulse", {44'd0, pul}, 48'd0);
    i_rst = 1'b0;

    // Initial clear: DEPTH edges until ready, reads return 0, no range pulses
    p2r(11'd1500);
    for (int k = 1; k <= DEPTH; k++) begin
      p1r(AW'(k % DEPTH));
      tick();
      if (k == 1 || k == 700 || k == DEPTH - 1) begin
        chk($sformatf("init_clr_d1_%0d", k), o_data1, 48'd0);
        chk($sformatf("init_clr_pulse_%0d", k), {44'd0, pul}, 48'd0);
      end
      if (k == DEPTH - 1) chk("init_ready_low", 48'(o_ready), 48'd0);
      if (k == DEPTH)     chk("init_ready_high", 48'(o_ready), 48'd1);
    end

    // Byte-enable writes, read-first behaviour
    p1w(11'd5, 48'hAABBCCDDEEFF, 6'h3F); p2r(11'd0);
    push("wr5", 1, 48'd0, 1, 48'd0, 4'b0000); tick();
    p1r(11'd5); p2w(11'd5, 48'h11, 6'h01);
    push("be5", 1, 48'hAABBCCDDEEFF, 1, 48'hAABBCCDDEEFF, 4'b0000); tick();
    p1r(11'd5); p2r(11'd5);
    push("rd5", 1, 48'hAABBCCDDEE11, 1, 48'hAABBCCDDEE11, 4'b0000); tick();

    // Full and partial collisions
    p1w(11'd10, 48'h1, 6'h3F); p2w(11'd10, 48'h2, 6'h3F);
    push("coll10", 1, 48'd0, 1, 48'd0, 4'b0010); tick();
    p1r(11'd10); p2r(11'd10);
    push("rd10", 1, 48'h1, 1, 48'h1, 4'b0000); tick();
    p1w(11'd20, 48'hAA, 6'h01); p2w(11'd20, 48'hBBCC, 6'h03);
    push("pcoll20", 1, 48'd0, 1, 48'd0, 4'b0010); tick();
    p1r(11'd20); p2r(11'd20);
    push("rd20", 1, 48'hBBAA, 1, 48'hBBAA, 4'b0000); tick();

    // Doorbells on START word (512)
    p1w(11'd512, 48'h1, 6'h02); p2r(11'd0);
    push("nostart_be", 1, 48'd0, 1, 48'd0, 4'b0000); tick();
    p1w(11'd512, 48'h1, 6'h01); p2r(11'd512);
    push("start", 1, 48'd0, 1, 48'd0, 4'b1000); tick();
    p1r(11'd512); p2w(11'd512, 48'h0, 6'h3F);
    push("step", 1, 48'h1, 1, 48'h1, 4'b0100); tick();
    p1r(11'd512); p2r(11'd512);
    push("rd512", 1, 48'd0, 1, 48'd0, 4'b0000); tick();
    p1w(11'd512, 48'h0, 6'h01); p2w(11'd512, 48'h0, 6'h01);
    push("coll_start", 1, 48'd0, 1, 48'd0, 4'b0010); tick();

    // Range checks and last valid word
    p2w(11'd1400, 48'hFFFF, 6'h3F); p1r(11'd1359);
    push("oor_wr", 1, 48'd0, 1, 48'd0, 4'b0001); tick();
    p1r(11'd40); p2r(11'd376);
    push("oor_alias", 1, 48'd0, 1, 48'd0, 4'b0000); tick();
    p1r(11'h7FF); p2r(11'd1360);
    push("oor_rd", 1, 48'd0, 1, 48'd0, 4'b0001); tick();
    p1w(11'd1359, 48'h123456789ABC, 6'h3F); p2r(11'd0);
    push("wr_last", 1, 48'd0, 1, 48'd0, 4'b0000); tick();
    p1r(11'd0); p2r(11'd1359);
    push("rd_last", 1, 48'd0, 1, 48'h123456789ABC, 4'b0000); tick();

    // Clear pulse in IDLE: ready drops on the next cycle
    i_clear = 1'b1; p1r(11'd5); p2r(11'd10);
    push("clear_edge", 1, 48'hAABBCCDDEE11, 1, 48'h1, 4'b0000); tick();
    i_clear = 1'b0;
    chk("clear_ready_low", 48'(o_ready), 48'd0);

    // Writes, doorbells and collisions during CLEAR are ignored
    for (int j = 1; j <= DEPTH; j++) begin
      if (j <= 10) begin
        if (j % 2 == 1) begin
          p1w(11'd0, 48'hDEAD, 6'h3F); p2w(11'd0, 48'hBEEF, 6'h3F);
        end else begin
          p1w(11'd512, 48'h1, 6'h01); p2w(11'd1500, 48'h5, 6'h3F);
        end
        push($sformatf("inclr%0d", j), 1, 48'd0, 1, 48'd0, 4'b0000);
      end else begin
        p1r(11'd0); p2r(11'd0);
      end
      tick();
      if (j == DEPTH - 1) chk("reclr_ready_low", 48'(o_ready), 48'd0);
      if (j == DEPTH)     chk("reclr_ready_high", 48'(o_ready), 48'd1);
    end

    // Every word reads 0 after the clear
    for (int i = 0; i < DEPTH; i++) begin
      p1r(AW'(i)); p2r(AW'(DEPTH - 1 - i));
      push($sformatf("clr_rd%0d", i), 1, 48'd0, 1, 48'd0, 4'b0000);
      tick();
    end

    // Reset mid-operation forces outputs low immediately
    p1w(11'd512, 48'h1, 6'h01); p2r(11'd0);
    push("start2", 1, 48'd0, 1, 48'd0, 4'b1000); tick();
    p1r(11'd512);
    i_rst = 1'b1;
    #1;
    chk("midrst_start", 48'(o_start), 48'd0);
    chk("midrst_ready", 48'(o_ready), 48'd0);
    chk("midrst_d1", o_data1, 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
